uart_alu_if: RTL

UART_ALU_IF -- requirements
Module: uart_alu_if

---
 rtl/uart_alu_if.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_alu_if
//  Function : Bridges a UART RX/TX FIFO pair to a combinational ALU. Pops
//             operand A, operand B and an opcode byte, latches the ALU
//             result, then pushes it as a single reply byte.
//  Option   : UART_ALU_TIMEOUT_EN - enables an inter-byte timeout that aborts
//             a partial transaction and pulses o_timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_alu_if #(
   parameter int DBIT        = 8,
   parameter int NB_OP       = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_rx_empty,
   input  logic [DBIT-1:0]  i_r_data,
   output logic             o_rd_uart,
   input  logic             i_tx_full,
   output logic             o_wr_uart,
   output logic [DBIT-1:0]  o_w_data,
   output logic [DBIT-1:0]  o_alu_a,
   output logic [DBIT-1:0]  o_alu_b,
   output logic [NB_OP-1:0] o_alu_op,
   input  logic [DBIT-1:0]  i_alu_result,
   output logic             o_timeout
);

   typedef enum logic [2:0] {
      GET_A  = 3'd0,
      GET_B  = 3'd1,
      GET_OP = 3'd2,
      LATCH  = 3'd3,
      SEND   = 3'd4
   } state_t;

   state_t           state_q;
   logic [DBIT-1:0]  alu_a_q;
   logic [DBIT-1:0]  alu_b_q;
   logic [NB_OP-1:0] alu_op_q;
   logic [DBIT-1:0]  w_data_q;
   logic             get_state;
   logic             expire;

   assign get_state = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);

   // Strobes are combinational so a pop/push lands on the same edge the data is used;
   // gating with reset keeps them quiet while reset is held.
   assign o_rd_uart = i_reset & get_state & ~i_rx_empty;
   assign o_wr_uart = i_reset & (state_q == SEND) & ~i_tx_full;

   assign o_alu_a  = alu_a_q;
   assign o_alu_b  = alu_b_q;
   assign o_alu_op = alu_op_q;
   assign o_w_data = w_data_q;

`ifdef UART_ALU_TIMEOUT_EN
   localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             timeout_q;
   logic             waiting;

   // Waiting for B or opcode with nothing to pop; a pop always resets the count.
   assign waiting = i_rx_empty && ((state_q == GET_B) || (state_q == GET_OP));
   assign expire  = waiting && (tmo_cnt_q == CNT_LAST);

   // Inter-byte timeout counter and one-cycle abort pulse.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= expire;
         if (waiting && !expire) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end else begin
            tmo_cnt_q <= '0;
         end
      end
   end

   assign o_timeout = timeout_q;
`else
   assign expire    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // Transaction sequencer: capture A, B, opcode, latch the result, then push it.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q  <= GET_A;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         w_data_q <= '0;
      end else begin
         case (state_q)
            GET_A: begin
               if (!i_rx_empty) begin
                  alu_a_q <= i_r_data;
                  state_q <= GET_B;
               end
            end
            GET_B: begin
               if (!i_rx_empty) begin
                  alu_b_q <= i_r_data;
                  state_q <= GET_OP;
               end else if (expire) begin
                  state_q <= GET_A;
               end
            end
            GET_OP: begin
               if (!i_rx_empty) begin
                  alu_op_q <= i_r_data[NB_OP-1:0];
                  state_q  <= LATCH;
               end else if (expire) begin
                  state_q <= GET_A;
               end
            end
            LATCH: begin
               w_data_q <= i_alu_result;
               state_q  <= SEND;
            end
            SEND: begin
               if (!i_tx_full) begin
                  state_q <= GET_A;
               end
            end
            default: begin
               state_q <= GET_A;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
